// File: rtl/selftrig_buffer_swap_master.sv
// rtl/selftrig_buffer_swap_master.sv - master controller for self-triggered DDR3 double buffering
//
// Drives enable_triggering/ddr3_buffer to the channel FPGAs and flips ddr3_buffer every
// swap_interval cycles. After each flip it waits for all enabled channels to report the retired
// buffer complete, then hands that buffer to readout via readout_req/readout_ack. Stopping the
// run drains the final buffer the same way.
//
// Optional feature: define EXT_SWAP_EN to add ext_swap_req. A synchronised rising edge on it
// forces a flip while in RUN. Edges seen in any other state are dropped.
//
// Ports:
//   clk50, reset_clk50          clock and asynchronous active-high reset
//   run_enable, swap_interval   software run control and flip period (0 = no periodic flips)
//   chan_enable                 channel mask; masked channels never block progress
//   ext_done, ext_done_buffer   async per-channel idle / buffer-complete flags (ch n at [2n+1:2n])
//   readout_ack                 one-cycle pulse that ends a readout handshake
//   enable_triggering, ddr3_buffer            outputs to the channel FPGAs
//   readout_req, readout_buffer               readout handshake to the readout engine
//   swap_count, timeout_err, chan_timeout_mask, sm_idle   status outputs
module selftrig_buffer_swap_master #(
  parameter int NUM_CHAN     = 5,
  parameter int GUARD_CYC    = 16,
  parameter int DONE_TIMEOUT = 50000
) (
  input  logic                  clk50,
  input  logic                  reset_clk50,
  input  logic                  run_enable,
  input  logic [31:0]           swap_interval,
  input  logic [NUM_CHAN-1:0]   chan_enable,
  input  logic [NUM_CHAN-1:0]   ext_done,
  input  logic [2*NUM_CHAN-1:0] ext_done_buffer,
  input  logic                  readout_ack,
`ifdef EXT_SWAP_EN
  input  logic                  ext_swap_req,
`endif
  output logic                  enable_triggering,
  output logic                  ddr3_buffer,
  output logic                  readout_req,
  output logic                  readout_buffer,
  output logic [31:0]           swap_count,
  output logic                  timeout_err,
  output logic [NUM_CHAN-1:0]   chan_timeout_mask,
  output logic                  sm_idle
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARM, S_RUN, S_FLIP, S_GUARD, S_WAIT_DONE, S_READOUT, S_STOP, S_DRAIN, S_FINAL
  } state_t;

  localparam logic [31:0] GUARD_LAST = 32'(GUARD_CYC - 1);
  localparam logic [31:0] TO_LAST    = 32'(DONE_TIMEOUT - 1);

  state_t                  state_q;
  logic [31:0]             cnt_q;
  logic                    en_trig_q, ddr3_q, req_q, rbuf_q, terr_q, idle_q;
  logic [31:0]             swap_cnt_q;
  logic [NUM_CHAN-1:0]     tmask_q;

  (* ASYNC_REG = "TRUE" *) logic [NUM_CHAN-1:0]   done_s1_q, done_s2_q;
  (* ASYNC_REG = "TRUE" *) logic [2*NUM_CHAN-1:0] dbuf_s1_q, dbuf_s2_q;

  logic [NUM_CHAN-1:0] buf_flag;
  logic [NUM_CHAN-1:0] buf_missing, drain_missing;
  logic                buf_all_done, drain_all_done, swap_edge;
  logic [31:0]         cnt_inc_d;

  // Select each channel's flag for the buffer that was just retired.
  always_comb begin
    buf_flag = '0;
    for (int n = 0; n < NUM_CHAN; n++) begin
      buf_flag[n] = rbuf_q ? dbuf_s2_q[2*n+1] : dbuf_s2_q[2*n];
    end
  end

  // Masked channels count as done, so an all-zero mask is always "all done".
  assign buf_missing    = chan_enable & ~buf_flag;
  assign drain_missing  = chan_enable & ~done_s2_q;
  assign buf_all_done   = (buf_missing == '0);
  assign drain_all_done = (drain_missing == '0);
  assign cnt_inc_d      = cnt_q + 32'd1;

`ifdef EXT_SWAP_EN
  (* ASYNC_REG = "TRUE" *) logic [1:0] swp_sync_q;
  logic swp_last_q;
  always_ff @(posedge clk50 or posedge reset_clk50) begin
    if (reset_clk50) begin
      swp_sync_q <= '0;
      swp_last_q <= 1'b0;
    end else begin
      swp_sync_q <= {swp_sync_q[0], ext_swap_req};
      swp_last_q <= swp_sync_q[1];
    end
  end
  assign swap_edge = swp_sync_q[1] & ~swp_last_q;
`else
  assign swap_edge = 1'b0;
`endif

  always_ff @(posedge clk50 or posedge reset_clk50) begin
    if (reset_clk50) begin
      done_s1_q <= '0;
      done_s2_q <= '0;
      dbuf_s1_q <= '0;
      dbuf_s2_q <= '0;
    end else begin
      done_s1_q <= ext_done;
      done_s2_q <= done_s1_q;
      dbuf_s1_q <= ext_done_buffer;
      dbuf_s2_q <= dbuf_s1_q;
    end
  end

  // cnt_q is shared: guard/timeout up-counter, or the interval down-counter while in RUN.
  always_ff @(posedge clk50 or posedge reset_clk50) begin
    if (reset_clk50) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      en_trig_q  <= 1'b0;
      ddr3_q     <= 1'b0;
      req_q      <= 1'b0;
      rbuf_q     <= 1'b0;
      swap_cnt_q <= '0;
      terr_q     <= 1'b0;
      tmask_q    <= '0;
      idle_q     <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run_enable) begin
            state_q    <= S_ARM;
            idle_q     <= 1'b0;
            terr_q     <= 1'b0;
            tmask_q    <= '0;
            swap_cnt_q <= '0;
            ddr3_q     <= 1'b0;
            en_trig_q  <= 1'b0;
            cnt_q      <= '0;
          end
        end
        S_ARM: begin
          if (cnt_q == GUARD_LAST) begin
            state_q   <= S_RUN;
            en_trig_q <= 1'b1;
            cnt_q     <= swap_interval;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_RUN: begin
          if (!run_enable) begin
            state_q   <= S_STOP;
            en_trig_q <= 1'b0;
            cnt_q     <= '0;
          end else if (swap_edge || cnt_q == 32'd1) begin
            state_q    <= S_FLIP;
            ddr3_q     <= ~ddr3_q;
            rbuf_q     <= ddr3_q;
            swap_cnt_q <= swap_cnt_q + 32'd1;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        S_FLIP: begin
          state_q <= S_GUARD;
          cnt_q   <= '0;
        end
        S_GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_q <= S_WAIT_DONE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_WAIT_DONE: begin
          if (buf_all_done) begin
            state_q <= S_READOUT;
            req_q   <= 1'b1;
          end else if (cnt_q == TO_LAST) begin
            state_q <= S_READOUT;
            req_q   <= 1'b1;
            terr_q  <= 1'b1;
            tmask_q <= tmask_q | buf_missing;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_READOUT: begin
          // The handshake always completes; run_enable is only sampled on the ack cycle.
          if (readout_ack) begin
            req_q <= 1'b0;
            if (!run_enable) begin
              state_q   <= S_STOP;
              en_trig_q <= 1'b0;
              cnt_q     <= '0;
            end else begin
              state_q <= S_RUN;
              cnt_q   <= swap_interval;
            end
          end
        end
        S_STOP: begin
          if (cnt_q == GUARD_LAST) begin
            state_q <= S_DRAIN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_DRAIN: begin
          if (drain_all_done || cnt_q == TO_LAST) begin
            state_q <= S_FINAL;
            req_q   <= 1'b1;
            rbuf_q  <= ddr3_q;
            if (!drain_all_done) begin
              terr_q  <= 1'b1;
              tmask_q <= tmask_q | drain_missing;
            end
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_FINAL: begin
          if (readout_ack) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            idle_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  assign enable_triggering = en_trig_q;
  assign ddr3_buffer       = ddr3_q;
  assign readout_req       = req_q;
  assign readout_buffer    = rbuf_q;
  assign swap_count        = swap_cnt_q;
  assign timeout_err       = terr_q;
  assign chan_timeout_mask = tmask_q;
  assign sm_idle           = idle_q;

endmodule

// File: tb/tb_selftrig_buffer_swap_master.sv
// tb/tb_selftrig_buffer_swap_master.sv - directed self-checking bench for selftrig_buffer_swap_master
module tb_selftrig_buffer_swap_master;
  localparam int NC = 5;
  localparam int GC = 16;
  localparam int TO = 300;

  logic          clk50 = 1'b0;
  logic          reset_clk50 = 1'b1;
  logic          run_enable = 1'b0;
  logic [31:0]   swap_interval = 32'd1000;
  logic [NC-1:0] chan_enable = 5'h1f;
  logic [NC-1:0] ext_done = '0;
  logic [2*NC-1:0] ext_done_buffer = '0;
  logic          readout_ack = 1'b0;
`ifdef EXT_SWAP_EN
  logic          ext_swap_req = 1'b0;
`endif
  logic          enable_triggering, ddr3_buffer, readout_req, readout_buffer;
  logic [31:0]   swap_count;
  logic          timeout_err, sm_idle;
  logic [NC-1:0] chan_timeout_mask;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n;

  selftrig_buffer_swap_master #(.NUM_CHAN(NC), .GUARD_CYC(GC), .DONE_TIMEOUT(TO)) dut (
    .clk50(clk50), .reset_clk50(reset_clk50), .run_enable(run_enable),
    .swap_interval(swap_interval), .chan_enable(chan_enable), .ext_done(ext_done),
    .ext_done_buffer(ext_done_buffer), .readout_ack(readout_ack),
`ifdef EXT_SWAP_EN
    .ext_swap_req(ext_swap_req),
`endif
    .enable_triggering(enable_triggering), .ddr3_buffer(ddr3_buffer),
    .readout_req(readout_req), .readout_buffer(readout_buffer), .swap_count(swap_count),
    .timeout_err(timeout_err), .chan_timeout_mask(chan_timeout_mask), .sm_idle(sm_idle)
  );

  always #5 clk50 = ~clk50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk50);
  endtask

  task automatic wait_req(input int max, output int cyc);
    cyc = 0;
    while (!readout_req && cyc < max) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic wait_flip(input int max, output int cyc);
    logic b;
    b = ddr3_buffer;
    cyc = 0;
    while (ddr3_buffer == b && cyc < max) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic pulse_ack();
    readout_ack = 1'b1;
    tick(1);
    readout_ack = 1'b0;
  endtask

  task automatic check_reset(input string p);
    check({p, "_en_trig"}, enable_triggering, 0);
    check({p, "_ddr3"},    ddr3_buffer, 0);
    check({p, "_req"},     readout_req, 0);
    check({p, "_rbuf"},    readout_buffer, 0);
    check({p, "_swaps"},   swap_count, 0);
    check({p, "_terr"},    timeout_err, 0);
    check({p, "_tmask"},   chan_timeout_mask, 0);
    check({p, "_idle"},    sm_idle, 1);
  endtask

  initial begin
    tick(3);
    reset_clk50 = 1'b0;
    tick(1);
    check_reset("rst");

    // Start: ARM for GC cycles, then RUN; first flip swap_interval cycles later.
    run_enable = 1'b1;
    tick(1);
    check("arm_idle", sm_idle, 0);
    tick(GC - 1);
    check("arm_en_trig", enable_triggering, 0);
    tick(1);
    check("run_en_trig", enable_triggering, 1);
    tick(999);
    check("preflip_ddr3", ddr3_buffer, 0);
    tick(1);
    check("flip1_ddr3", ddr3_buffer, 1);
    check("flip1_swaps", swap_count, 1);

    // All channels report buffer 0 complete 40 cycles after the flip.
    tick(40);
    check("t2_wait_req", readout_req, 0);
    ext_done_buffer = 10'h155;
    wait_req(200, n);
    check("t2_req", readout_req, 1);
    check("t2_rbuf", readout_buffer, 0);
    check("t2_swaps", swap_count, 1);
    check("t2_terr", timeout_err, 0);
    pulse_ack();
    check("t2_req_clr", readout_req, 0);
    ext_done_buffer = '0;

    // Channel 3 never reports buffer 1 complete: timeout path.
    wait_flip(1100, n);
    check("t3_ddr3", ddr3_buffer, 0);
    check("t3_rbuf", readout_buffer, 1);
    check("t3_swaps", swap_count, 2);
    ext_done_buffer = 10'h22a;
    tick(100);
    check("t3_no_early_req", readout_req, 0);
    wait_req(400, n);
    check("t3_req", readout_req, 1);
    check("t3_terr", timeout_err, 1);
    check("t3_tmask", chan_timeout_mask, 5'b01000);
    pulse_ack();
    ext_done_buffer = '0;

    // Channel 3 masked off: no timeout, prompt readout.
    chan_enable = 5'b10111;
    wait_flip(1100, n);
    check("t4_ddr3", ddr3_buffer, 1);
    check("t4_rbuf", readout_buffer, 0);
    check("t4_swaps", swap_count, 3);
    ext_done_buffer = 10'h115;
    wait_req(300, n);
    check("t4_req", readout_req, 1);
    check("t4_fast", (n < 100) ? 32'd1 : 32'd0, 1);
    check("t4_tmask", chan_timeout_mask, 5'b01000);

    // Stop during READOUT: handshake held, then STOP, DRAIN, FINAL, IDLE.
    run_enable = 1'b0;
    tick(3);
    check("t5_req_held", readout_req, 1);
    pulse_ack();
    check("t5_req_clr", readout_req, 0);
    check("t5_en_trig", enable_triggering, 0);
    check("t5_not_idle", sm_idle, 0);
    run_enable = 1'b1;
    tick(5);
    run_enable = 1'b0;
    tick(25);
    check("t5_drain_wait", readout_req, 0);
    check("t5_drain_en_trig", enable_triggering, 0);
    ext_done = 5'h17;
    wait_req(100, n);
    check("t5_final_req", readout_req, 1);
    check("t5_final_rbuf", readout_buffer, 1);
    check("t5_final_idle", sm_idle, 0);
    pulse_ack();
    check("t5_idle", sm_idle, 1);
    check("t5_idle_req", readout_req, 0);
    tick(5);
    check("t5_stay_idle", sm_idle, 1);

    // swap_interval=0: no periodic flips; status cleared on IDLE->ARM.
    swap_interval = 32'd0;
    chan_enable = 5'h1f;
    run_enable = 1'b1;
    tick(1);
    check("t6_swaps_clr", swap_count, 0);
    check("t6_terr_clr", timeout_err, 0);
    check("t6_tmask_clr", chan_timeout_mask, 0);
    tick(3000);
    check("t6_swaps", swap_count, 0);
    check("t6_ddr3", ddr3_buffer, 0);
    check("t6_en_trig", enable_triggering, 1);
`ifdef EXT_SWAP_EN
    ext_swap_req = 1'b1;
    tick(3);
    ext_swap_req = 1'b0;
    tick(50);
    check("t6_ext_swaps", swap_count, 1);
    check("t6_ext_ddr3", ddr3_buffer, 1);
`endif

    // Reset while a READOUT handshake is pending.
    reset_clk50 = 1'b1;
    tick(1);
    reset_clk50 = 1'b0;
    swap_interval = 32'd5;
    ext_done_buffer = 10'h3ff;
    run_enable = 1'b1;
    wait_req(200, n);
    check("t1_req", readout_req, 1);
    check("t1_idle", sm_idle, 0);
    reset_clk50 = 1'b1;
    tick(1);
    check_reset("rst2");
    reset_clk50 = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
